// File: rtl/ysyx_220053_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular FIFO of {pc, instr} pairs
// between fetch and decode. Handshake readiness depends only on registered
// occupancy and flush, so out_ready never reaches in_ready combinationally.
module ysyx_220053_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     cnt;
    logic               push;
    logic               pop;

    // Handshake and head-entry presentation; full/empty come from cnt only
    always_comb begin
        in_ready  = (cnt != FULL_CNT) && !flush;
        out_valid = (cnt != '0) && !flush;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_pc    = out_valid ? mem[head].pc    : 64'd0;
        out_instr = out_valid ? mem[head].instr : 32'd0;
        count     = cnt;
    end

    // Entry storage: written at tail on an accepted push, never reset
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[tail] <= '{pc: in_pc, instr: in_instr};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220053_fetch_queue.sv
// Bench for the fetch queue: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_ysyx_220053_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = 64'd0;
    logic [31:0] in_instr = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [PTR_W:0] count;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    // Reference: a plain queue of {pc, instr}, front is the head entry
    logic [95:0] q[$];
    bit m_push, m_pop;
    logic        e_valid, e_ready;
    logic [63:0] e_pc;
    logic [31:0] e_instr;

    ysyx_220053_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT updates
    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            m_pop  = (q.size() != 0) && out_ready;
            m_push = (q.size() != DEPTH) && in_valid;
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back({in_pc, in_instr});
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (en) begin
            e_valid = (q.size() != 0) && !flush;
            e_ready = (q.size() != DEPTH) && !flush;
            e_pc    = e_valid ? q[0][95:32] : 64'd0;
            e_instr = e_valid ? q[0][31:0]  : 32'd0;
            chk("m_out_valid", 64'(out_valid), 64'(e_valid));
            chk("m_in_ready",  64'(in_ready),  64'(e_ready));
            chk("m_out_pc",    out_pc,         e_pc);
            chk("m_out_instr", 64'(out_instr), 64'(e_instr));
            chk("m_count",     64'(count),     64'(q.size()));
            chk("count_range", 64'(count <= 3'd4), 64'd1);
        end
    end

    task automatic cyc(input logic v, input logic r, input logic f, input logic rs,
                       input logic [63:0] pc);
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        rst       = rs;
        in_pc     = pc;
        in_instr  = pc[31:0] ^ 32'h0000_0013;
        #1;
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] pc;
        int rbias;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_out_pc",    out_pc,         64'd0);

        // Fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 64'h8000_0000 + 64'(4 * i));
            chk("fill_in_ready", 64'(in_ready), 64'd1);
        end
        cyc(1, 0, 0, 0, 64'h8000_0010);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count",    64'(count),    64'd4);
        chk("full_out_pc",   out_pc,        64'h8000_0000);
        cyc(0, 0, 0, 0, 64'd0);
        chk("full_hold_count", 64'(count), 64'd4);
        chk("full_hold_pc",    out_pc,      64'h8000_0000);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 64'd0);
            chk("drain_pc",    out_pc,      64'h8000_0000 + 64'(4 * i));
            chk("drain_count", 64'(count), 64'(4 - i));
        end
        cyc(0, 0, 0, 0, 64'd0);
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_count", 64'(count),     64'd0);
        chk("empty_pc",    out_pc,         64'd0);

        // Streaming at occupancy 2
        base = 64'h8000_0100;
        cyc(1, 0, 0, 0, base);
        cyc(1, 0, 0, 0, base + 64'd4);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, base + 64'd8 + 64'(4 * i));
            chk("stream_count", 64'(count), 64'd2);
            chk("stream_pc",    out_pc,      base + 64'(4 * i));
        end

        // Drain, refill to 3, then flush alongside push and pop
        cyc(0, 1, 0, 0, 64'd0);
        cyc(0, 1, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 64'h8000_0200 + 64'(4 * i));
        cyc(1, 1, 1, 0, 64'h8000_020C);
        chk("flush_count",     64'(count),     64'd3);
        chk("flush_in_ready",  64'(in_ready),  64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_pc",    out_pc,         64'd0);
        cyc(1, 0, 0, 0, 64'h8000_1000);
        chk("post_flush_count", 64'(count),    64'd0);
        chk("post_flush_ready", 64'(in_ready), 64'd1);
        cyc(0, 0, 0, 0, 64'd0);
        chk("redirect_valid", 64'(out_valid), 64'd1);
        chk("redirect_pc",    out_pc,         64'h8000_1000);
        chk("redirect_count", 64'(count),     64'd1);
        cyc(0, 1, 0, 0, 64'd0);

        // Random stress with a drifting decode-ready bias
        pc = 64'h8000_2000;
        rbias = 2;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) rbias = $urandom_range(0, 4);
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 4) < rbias,
                $urandom_range(0, 31) == 0,
                $urandom_range(0, 299) == 0,
                pc);
            pc = pc + 64'd4;
        end
        cyc(0, 0, 0, 0, 64'd0);
        @(posedge clk);
        #1;
        en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
